// File: rtl/mips_pkg.sv
// Shared encodings for the iterative multiply/divide unit of the MIPS pipeline.
// Op and state encodings plus small decode helpers used by the sequencer and its step logic.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIN  = 2'b10
    } mdState_t;

    function automatic logic isDivOp(input mdOp_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input mdOp_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute/Decode-side bundle between the pipeline and the multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic [1:0]       OpE;
    logic             MtHiE;
    logic             MtLoE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             FlushE;
    logic             HiLoReadD;
    logic             StallMD;
    logic             Busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             DivZero;

    modport master (
        output StartE, OpE, MtHiE, MtLoE, SrcAE, SrcBE, FlushE, HiLoReadD,
        input  StallMD, Busy, HI, LO, DivZero
    );

    modport slave (
        input  StartE, OpE, MtHiE, MtLoE, SrcAE, SrcBE, FlushE, HiLoReadD,
        output StallMD, Busy, HI, LO, DivZero
    );
endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// Accumulator holds {upper, lower}: {partial product, multiplier} or {remainder, quotient}.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdOp_t              op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] accNext
);

    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] diffLow;
    logic             trialOk;

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        addSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        remShift = acc[2*WIDTH-1:WIDTH-1];
        trialOk  = (remShift >= {1'b0, operand});
        // A successful trial leaves a remainder below the divisor, so the low WIDTH bits are exact.
        diffLow  = remShift[WIDTH-1:0] - operand;
        accNext  = '0;
        if (isDivOp(op)) begin
            if (trialOk) begin
                accNext = {diffLow, acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            accNext = {addSum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative MULT/MULTU/DIV/DIVU unit and the HI/LO pair.
// Owns the IDLE->RUN->FIN FSM, iteration counter, sign handling, HI/LO writes and stall request.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_ctrl_if.slave md
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdState_t           state;
    mdState_t           stateNext;
    mdOp_t              opIn;
    mdOp_t              opR;
    logic               accept;
    logic               mtWrite;
    logic               busy;
    logic               signedIn;
    logic               aNeg;
    logic               bNeg;
    logic               signA;
    logic               signB;
    logic               finDivZero;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH-1:0]   operandR;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;
    logic [WIDTH-1:0]   hiR;
    logic [WIDTH-1:0]   loR;
    logic               divZeroR;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] prodFixed;
    logic [CNT_W-1:0]   count;

    assign opIn     = mdOp_t'(md.OpE);
    assign accept   = (state == MD_IDLE) && md.StartE && !md.FlushE;
    // StartE alongside MTHI/MTLO never comes from the decoder; if it does, the op wins.
    assign mtWrite  = (state == MD_IDLE) && !md.FlushE && !md.StartE;
    assign signedIn = isSignedOp(opIn);
    assign aNeg     = signedIn && md.SrcAE[WIDTH-1];
    assign bNeg     = signedIn && md.SrcBE[WIDTH-1];
    assign absA     = aNeg ? -md.SrcAE : md.SrcAE;
    assign absB     = bNeg ? -md.SrcBE : md.SrcBE;

    // State register
    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MD_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            MD_IDLE: if (accept) stateNext = MD_RUN;
            MD_RUN:  if (count == '0) stateNext = MD_FIN;
            MD_FIN:  stateNext = MD_IDLE;
            default: stateNext = MD_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state != MD_IDLE);
        md.Busy    = busy;
        md.StallMD = busy && (md.HiLoReadD || md.StartE || md.MtHiE || md.MtLoE);
    end

    // NOTE: the iteration datapath has no reset; it is always loaded on accept before the FSM looks at it.
    always_ff @(posedge clk) begin
        if (accept) begin
            opR   <= opIn;
            signA <= aNeg;
            signB <= bNeg;
            count <= CNT_W'(WIDTH - 1);
            if (isDivOp(opIn)) begin
                acc      <= {{WIDTH{1'b0}}, absA};
                operandR <= absB;
            end else begin
                acc      <= {{WIDTH{1'b0}}, absB};
                operandR <= absA;
            end
        end else if (state == MD_RUN) begin
            acc   <= accNext;
            count <= count - 1'b1;
        end
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) uIter (
        .op      (opR),
        .acc     (acc),
        .operand (operandR),
        .accNext (accNext)
    );

    // Sign correction on the unsigned magnitudes; negation wraps modulo the field width.
    always_comb begin
        prodFixed  = (signA ^ signB) ? -acc : acc;
        quot       = acc[WIDTH-1:0];
        rem        = acc[2*WIDTH-1:WIDTH];
        finDivZero = isDivOp(opR) && (operandR == '0);
        resHi      = prodFixed[2*WIDTH-1:WIDTH];
        resLo      = prodFixed[WIDTH-1:0];
        if (isDivOp(opR)) begin
            // With a zero divisor the remainder path reproduces the dividend magnitude.
            resHi = signA ? -rem : rem;
            if (finDivZero) begin
                resLo = '1;
            end else begin
                resLo = (signA ^ signB) ? -quot : quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hiR      <= '0;
            loR      <= '0;
            divZeroR <= 1'b0;
        end else if (state == MD_FIN) begin
            hiR      <= resHi;
            loR      <= resLo;
            divZeroR <= finDivZero;
        end else begin
            if (accept) divZeroR <= 1'b0;
            if (mtWrite && md.MtHiE) hiR <= md.SrcAE;
            if (mtWrite && md.MtLoE) loR <= md.SrcAE;
        end
    end

    assign md.HI      = hiR;
    assign md.LO      = loR;
    assign md.DivZero = divZeroR;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, multi-cycle hazard sequences,
// and random ops checked against a plain-arithmetic reference model.
module tb_muldiv_ctrl;
    import mips_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.WIDTH(W)) mdIf ();

    muldiv_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (mdIf)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expDz;
    } vec_t;

    vec_t vecs[10];
    int   nChecks = 0;
    int   nFail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        mdIf.StartE    = 1'b0;
        mdIf.OpE       = 2'b00;
        mdIf.MtHiE     = 1'b0;
        mdIf.MtLoE     = 1'b0;
        mdIf.SrcAE     = '0;
        mdIf.SrcBE     = '0;
        mdIf.FlushE    = 1'b0;
        mdIf.HiLoReadD = 1'b0;
    endtask

    // Leaves the caller at the negedge of cycle T+1 with StartE low.
    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdIf.StartE = 1'b1;
        mdIf.OpE    = op;
        mdIf.SrcAE  = a;
        mdIf.SrcBE  = b;
        @(negedge clk);
        mdIf.StartE = 1'b0;
    endtask

    task automatic runAndCheck(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input logic expDz);
        int lat;
        startOp(op, a, b);
        lat = 1;
        while (mdIf.Busy === 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(LAT));
        check({name, " HI"}, 64'(mdIf.HI), 64'(expHi));
        check({name, " LO"}, 64'(mdIf.LO), 64'(expLo));
        check({name, " DivZero"}, 64'(mdIf.DivZero), 64'(expDz));
    endtask

    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned up;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        if (op == MD_MULT) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            hi = sp[63:32];
            lo = sp[31:0];
        end else if (op == MD_MULTU) begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else if (op == MD_DIV) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            hi = sr[31:0];
            lo = sq[31:0];
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endfunction

    initial begin
        int          errStall;
        int          errBusy;
        logic        expStall;
        logic        expBusy;
        logic [31:0] mHi;
        logic [31:0] mLo;
        logic        mDz;
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;

        vecs[0] = '{"mult 7*-3",        MD_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{"multu max*max",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{"div -7/2",         MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"divu 10/0",        MD_DIVU,  32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{"div overflow",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{"divu 100/7",       MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[6] = '{"div -5/0",         MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{"mult min*min",     MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{"div 7/-2",         MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{"mult -1*-1",       MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};

        idleInputs();
        repeat (2) @(negedge clk);
        check("reset Busy", 64'(mdIf.Busy), 64'd0);
        check("reset StallMD", 64'(mdIf.StallMD), 64'd0);
        check("reset HI", 64'(mdIf.HI), 64'd0);
        check("reset LO", 64'(mdIf.LO), 64'd0);
        check("reset DivZero", 64'(mdIf.DivZero), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runAndCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                        vecs[i].expHi, vecs[i].expLo, vecs[i].expDz);
        end

        // MFHI in Decode from T+5 while a DIVU runs; a flushed Execute slot must not cancel it.
        errStall = 0;
        @(negedge clk);
        mdIf.StartE = 1'b1;
        mdIf.OpE    = MD_DIVU;
        mdIf.SrcAE  = 32'd100;
        mdIf.SrcBE  = 32'd7;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            mdIf.StartE    = 1'b0;
            mdIf.HiLoReadD = (c >= 5);
            mdIf.FlushE    = (c == 2 || c == 3);
            #1;
            expStall = (c >= 5 && c <= LAT - 1);
            if (mdIf.StallMD !== expStall) errStall++;
        end
        check("hiloread stall window", 64'(errStall), 64'd0);
        check("hiloread HI", 64'(mdIf.HI), 64'd2);
        check("hiloread LO", 64'(mdIf.LO), 64'd14);
        check("hiloread Busy end", 64'(mdIf.Busy), 64'd0);
        mdIf.HiLoReadD = 1'b0;

        // Back-to-back ops: the second is held in Execute from T+3 and accepted at T+34.
        errStall = 0;
        errBusy  = 0;
        @(negedge clk);
        mdIf.StartE = 1'b1;
        mdIf.OpE    = MD_MULT;
        mdIf.SrcAE  = 32'd7;
        mdIf.SrcBE  = 32'hFFFF_FFFD;
        for (int c = 1; c <= 2 * LAT; c++) begin
            @(negedge clk);
            if (c == 1) mdIf.StartE = 1'b0;
            if (c == 3) begin
                mdIf.StartE = 1'b1;
                mdIf.OpE    = MD_DIVU;
                mdIf.SrcAE  = 32'd100;
                mdIf.SrcBE  = 32'd7;
            end
            if (c == LAT + 1) mdIf.StartE = 1'b0;
            #1;
            expStall = (c >= 3 && c <= LAT - 1);
            expBusy  = (c <= LAT - 1) || (c >= LAT + 1 && c <= 2 * LAT - 1);
            if (mdIf.StallMD !== expStall) errStall++;
            if (mdIf.Busy !== expBusy) errBusy++;
            if (c == LAT) begin
                check("b2b first HI", 64'(mdIf.HI), 64'hFFFF_FFFF);
                check("b2b first LO", 64'(mdIf.LO), 64'hFFFF_FFEB);
            end
        end
        check("b2b stall window", 64'(errStall), 64'd0);
        check("b2b busy window", 64'(errBusy), 64'd0);
        check("b2b second HI", 64'(mdIf.HI), 64'd2);
        check("b2b second LO", 64'(mdIf.LO), 64'd14);

        // Flushed Execute slot: neither an op nor an MTHI may take effect.
        errBusy = 0;
        @(negedge clk);
        mdIf.StartE = 1'b1;
        mdIf.FlushE = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (mdIf.Busy !== 1'b0) errBusy++;
        end
        check("flushed start Busy", 64'(errBusy), 64'd0);
        mdIf.StartE = 1'b0;
        mdIf.MtHiE  = 1'b1;
        mdIf.SrcAE  = 32'hDEAD_BEEF;
        @(negedge clk);
        mdIf.MtHiE  = 1'b0;
        mdIf.FlushE = 1'b0;
        check("flushed mthi HI", 64'(mdIf.HI), 64'd2);

        // MTHI then MTLO, then both in one cycle.
        mdIf.MtHiE = 1'b1;
        mdIf.SrcAE = 32'h1234;
        @(negedge clk);
        mdIf.MtHiE = 1'b0;
        mdIf.MtLoE = 1'b1;
        mdIf.SrcAE = 32'h5678;
        @(negedge clk);
        mdIf.MtLoE = 1'b0;
        check("mthi HI", 64'(mdIf.HI), 64'h1234);
        check("mtlo LO", 64'(mdIf.LO), 64'h5678);
        mdIf.MtHiE = 1'b1;
        mdIf.MtLoE = 1'b1;
        mdIf.SrcAE = 32'hCAFE_F00D;
        @(negedge clk);
        mdIf.MtHiE = 1'b0;
        mdIf.MtLoE = 1'b0;
        check("mt both HI", 64'(mdIf.HI), 64'hCAFE_F00D);
        check("mt both LO", 64'(mdIf.LO), 64'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            rB  = $urandom;
            case ($urandom_range(0, 7))
                0: rB = 32'd0;
                1: rB = $urandom_range(1, 15);
                2: rB = 32'hFFFF_FFFF;
                3: rA = 32'h8000_0000;
                default: ;
            endcase
            refModel(rOp, rA, rB, mHi, mLo, mDz);
            runAndCheck($sformatf("random %0d op%0d", i, rOp), rOp, rA, rB, mHi, mLo, mDz);
        end

        // Reset at T+10 of a MULT aborts it and clears HI/LO.
        @(negedge clk);
        mdIf.StartE = 1'b1;
        mdIf.OpE    = MD_MULT;
        mdIf.SrcAE  = 32'd7;
        mdIf.SrcBE  = 32'hFFFF_FFFD;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            mdIf.StartE = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort Busy", 64'(mdIf.Busy), 64'd0);
        check("abort HI", 64'(mdIf.HI), 64'd0);
        check("abort LO", 64'(mdIf.LO), 64'd0);
        rst_n = 1'b1;
        runAndCheck("after abort", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
